// File: rtl/rotsq_pkg.sv
// Shared types and constants for the rotating-square display controller.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package rotsq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } rotsq_state_t;

  // Segment patterns are g..a, active-low; dp is prepended by the user.
  localparam logic [6:0] SEG_TOP    = 7'b0011100;
  localparam logic [6:0] SEG_BOTTOM = 7'b0100011;
  localparam logic [7:0] SEG_BLANK  = 8'hFF;

  // Digit index plus which half of the loop the square is on.
  typedef struct packed {
    logic [2:0] digit;
    logic       bottom;
  } sq_loc_t;

  // The loop runs left-to-right along the top, then right-to-left along the bottom.
  function automatic sq_loc_t pos_to_digit(input logic [3:0] pos, input int n);
    sq_loc_t loc;
    int      p;
    p = int'(pos);
    if (p < n) begin
      loc.digit  = 3'(p);
      loc.bottom = 1'b0;
    end else begin
      loc.digit  = 3'(2 * n - 1 - p);
      loc.bottom = 1'b1;
    end
    return loc;
  endfunction

endpackage

// File: rtl/rotsq_scan.sv
// Anode scan: free-running refresh counter and digit index with one-hot-low decode.
// Latency: an_dec is combinational from the scan_idx register.
// Backpressure: none; runs continuously in every controller state.
module rotsq_scan #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 100_000
) (
  input  logic                          clk,
  input  logic                          reset,
  output logic [$clog2(NUM_DIGITS)-1:0] scan_idx,
  output logic [NUM_DIGITS-1:0]         an_dec
);

  localparam int IDX_W  = $clog2(NUM_DIGITS);
  // A divide-by-one still needs a one-bit counter that is always at its wrap value.
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_MAX  = IDX_W'(NUM_DIGITS - 1);

  logic [SCAN_W-1:0] scan_cnt;

  // Refresh divider; the digit index advances once per divider wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else if (scan_cnt == SCAN_MAX) begin
      scan_cnt <= '0;
      scan_idx <= (scan_idx == IDX_MAX) ? '0 : scan_idx + IDX_W'(1);
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

  // Only the digit being refreshed has its anode pulled low.
  always_comb begin
    an_dec           = '1;
    an_dec[scan_idx] = 1'b0;
  end

endmodule

// File: rtl/rotsq_disp_ctrl.sv
// Rotating-square controller for a NUM_DIGITS common-anode display; optional HOLD blink via ROTSQ_HOLD_BLINK_EN.
// Latency: an/sseg are registered, one cycle after state/pos/scan_idx.
// Backpressure: none; en holds the square in place, clr returns to a blank IDLE at position 0.
module rotsq_disp_ctrl
  import rotsq_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 25_000_000,
  parameter int SCAN_DIV   = 100_000
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              en,
  input  logic                              dir,
  input  logic                              clr,
  output logic [NUM_DIGITS-1:0]             an,
  output logic [7:0]                        sseg,
  output logic [$clog2(2*NUM_DIGITS)-1:0]   pos
);

  localparam int POS_W  = $clog2(2 * NUM_DIGITS);
  localparam int IDX_W  = $clog2(NUM_DIGITS);
  localparam int TICK_W = $clog2(TICK_DIV);
  localparam logic [POS_W-1:0]  POS_MAX  = POS_W'(2 * NUM_DIGITS - 1);
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICK_DIV - 1);

  rotsq_state_t        state;
  logic [TICK_W-1:0]   tick_cnt;
  logic [POS_W-1:0]    step_pos;
  logic [IDX_W-1:0]    scan_idx;
  logic [NUM_DIGITS-1:0] an_dec;
  sq_loc_t             loc;
  logic                hide;
  logic                lit;
  logic [6:0]          seg_pat;

  rotsq_scan #(
    .NUM_DIGITS (NUM_DIGITS),
    .SCAN_DIV   (SCAN_DIV)
  ) u_scan (
    .clk      (clk),
    .reset    (reset),
    .scan_idx (scan_idx),
    .an_dec   (an_dec)
  );

  // Next position around the loop, wrapping at both ends.
  always_comb begin
    if (dir) step_pos = (pos == POS_MAX) ? '0 : pos + POS_W'(1);
    else     step_pos = (pos == '0) ? POS_MAX : pos - POS_W'(1);
  end

  // Run/hold/clear state machine with the rotation step divider.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pos      <= '0;
      tick_cnt <= '0;
    end else if (clr) begin
      state    <= IDLE;
      pos      <= '0;
      tick_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          tick_cnt <= '0;
          if (en) state <= RUN;
        end
        RUN: begin
          // A step due on the cycle en drops is still taken.
          if (tick_cnt == TICK_MAX) begin
            tick_cnt <= '0;
            pos      <= step_pos;
          end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
          end
          if (!en) begin
            state <= HOLD;
`ifdef ROTSQ_HOLD_BLINK_EN
            // Blink phase restarts so the held square is lit first.
            tick_cnt <= '0;
`endif
          end
        end
        HOLD: begin
`ifdef ROTSQ_HOLD_BLINK_EN
          // Divider reused as the blink timebase; pos is untouched.
          tick_cnt <= (tick_cnt == TICK_MAX) ? '0 : tick_cnt + TICK_W'(1);
`endif
          if (en) state <= RUN;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ROTSQ_HOLD_BLINK_EN
  logic blink;

  // Blink flag toggles every TICK_DIV cycles in HOLD, cleared on entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink <= 1'b0;
    end else if (clr || (state == RUN && !en)) begin
      blink <= 1'b0;
    end else if (state == HOLD && tick_cnt == TICK_MAX) begin
      blink <= ~blink;
    end
  end

  assign hide = (state == HOLD) && blink;
`else
  assign hide = 1'b0;
`endif

  assign loc     = pos_to_digit(4'(pos), NUM_DIGITS);
  assign seg_pat = loc.bottom ? SEG_BOTTOM : SEG_TOP;
  assign lit     = (state != IDLE) && (loc.digit == 3'(scan_idx)) && !hide;

  // Registered pin drive; IDLE keeps every anode off.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an   <= '1;
      sseg <= SEG_BLANK;
    end else begin
      an   <= (state == IDLE) ? '1 : an_dec;
      sseg <= lit ? {1'b1, seg_pat} : SEG_BLANK;
    end
  end

endmodule

// File: tb/tb_rotsq_disp_ctrl.sv
// Self-checking bench for rotsq_disp_ctrl (N=4, TICK_DIV=4, SCAN_DIV=2).
// Per-cycle scoreboard of an/sseg/pos plus a directed vector table and hold/reset sequences.
// Honours ROTSQ_HOLD_BLINK_EN when the build defines it.
module tb_rotsq_disp_ctrl;

  localparam int N  = 4;
  localparam int TD = 4;
  localparam int SD = 2;
`ifdef ROTSQ_HOLD_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif
  localparam logic [7:0] TOP8 = 8'h9C;  // dp=1, g..a = 0011100
  localparam logic [7:0] BOT8 = 8'hA3;  // dp=1, g..a = 0100011

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       dir = 1'b1;
  logic       clr = 1'b0;
  logic [3:0] an;
  logic [7:0] sseg;
  logic [2:0] pos;

  rotsq_disp_ctrl #(
    .NUM_DIGITS (N),
    .TICK_DIV   (TD),
    .SCAN_DIV   (SD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .dir   (dir),
    .clr   (clr),
    .an    (an),
    .sseg  (sseg),
    .pos   (pos)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct packed {
    logic [3:0] an;
    logic [7:0] sseg;
    logic [2:0] pos;
  } obs_t;

  typedef struct {
    int st;     // 0 idle, 1 run, 2 hold
    int pos;
    int tick;
    int scnt;
    int sidx;
    bit blink;
  } mstate_t;

  mstate_t m;
  obs_t    exp_q[$];

  function automatic mstate_t model_next(input mstate_t c, input bit e, input bit d, input bit cl);
    mstate_t n;
    n = c;
    if (c.scnt == SD - 1) begin
      n.scnt = 0;
      n.sidx = (c.sidx + 1) % N;
    end else begin
      n.scnt = c.scnt + 1;
    end
    if (cl) begin
      n.st = 0; n.pos = 0; n.tick = 0; n.blink = 0;
    end else if (c.st == 0) begin
      n.tick = 0;
      if (e) n.st = 1;
    end else if (c.st == 1) begin
      if (c.tick == TD - 1) begin
        n.tick = 0;
        n.pos  = d ? (c.pos + 1) % (2 * N) : (c.pos + 2 * N - 1) % (2 * N);
      end else begin
        n.tick = c.tick + 1;
      end
      if (!e) begin
        n.st = 2;
        if (BLINK) begin n.tick = 0; n.blink = 0; end
      end
    end else begin
      if (BLINK) begin
        n.tick = (c.tick + 1) % TD;
        if (c.tick == TD - 1) n.blink = !c.blink;
      end
      if (e) n.st = 1;
    end
    return n;
  endfunction

  // Pins after an edge reflect the pre-edge model; pos reflects the post-edge model.
  function automatic obs_t model_obs(input mstate_t c, input mstate_t n);
    obs_t o;
    bit   bottom;
    int   dig;
    bottom = (c.pos >= N);
    dig    = bottom ? (2 * N - 1 - c.pos) : c.pos;
    o.an   = 4'hF;
    o.sseg = 8'hFF;
    o.pos  = 3'(n.pos);
    if (c.st != 0) begin
      o.an = 4'hF ^ (4'b0001 << c.sidx);
      if (dig == c.sidx && !(BLINK && c.st == 2 && c.blink))
        o.sseg = bottom ? BOT8 : TOP8;
    end
    return o;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m <= '{0, 0, 0, 0, 0, 1'b0};
      exp_q.delete();
    end else begin
      exp_q.push_back(model_obs(m, model_next(m, en, dir, clr)));
      m <= model_next(m, en, dir, clr);
    end
  end

  obs_t got, want;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      got  = '{an, sseg, pos};
      check("sb_an_sseg_pos", 32'(got), 32'(want));
    end
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    bit en;
    bit dir;
    bit clr;
    int cyc;
    int pos;
    bit blank;
  } vec_t;

  localparam int NV  = 24;
  localparam int P17 = BLINK ? 3 : 2;
  vec_t vec [NV];

  task automatic go_to(input int p, input bit d, input int cyc);
    clr = 1'b1; en = 1'b0;
    @(negedge clk);
    clr = 1'b0; en = 1'b1; dir = d;
    repeat (cyc) @(negedge clk);
    check($sformatf("goto%0d_pos", p), 32'(pos), 32'(p));
  endtask

  // Hold in place and inspect every sample where digit an_sel is being refreshed.
  task automatic hold_look(input string nm, input int cyc, input logic [3:0] an_sel,
                           input logic [7:0] seg_want, input int p);
    int hits;
    hits = 0;
    en = 1'b0;
    repeat (cyc) begin
      @(negedge clk);
      if (an === an_sel) begin
        hits++;
`ifndef ROTSQ_HOLD_BLINK_EN
        check({nm, "_sseg"}, 32'(sseg), 32'(seg_want));
`endif
      end
    end
    check({nm, "_digit_seen"}, 32'(hits > 0), 32'd1);
    check({nm, "_pos_held"}, 32'(pos), 32'(p));
  endtask

  initial begin
    vec[0] = '{1'b0, 1'b1, 1'b0, 50, 0, 1'b1};  // idle stays blank
    vec[1] = '{1'b1, 1'b1, 1'b0, 5,  1, 1'b0};  // first step TICK_DIV after RUN entry
    for (int i = 2; i <= 8; i++) vec[i] = '{1'b1, 1'b1, 1'b0, 4, i % 8, 1'b0};
    vec[9]  = '{1'b1, 1'b0, 1'b0, 4, 7, 1'b0};  // dir=0 wraps 0 -> 7
    vec[10] = '{1'b1, 1'b0, 1'b0, 4, 6, 1'b0};
    vec[11] = '{1'b1, 1'b0, 1'b0, 4, 5, 1'b0};
    vec[12] = '{1'b1, 1'b0, 1'b0, 4, 4, 1'b0};
    vec[13] = '{1'b1, 1'b0, 1'b0, 4, 3, 1'b0};
    vec[14] = '{1'b1, 1'b0, 1'b0, 2, 3, 1'b0};  // part-way through a step
    vec[15] = '{1'b0, 1'b0, 1'b0, 20, 3, 1'b0}; // hold
    vec[16] = '{1'b1, 1'b0, 1'b0, 1, 3, 1'b0};
    vec[17] = '{1'b1, 1'b0, 1'b0, 1, P17, 1'b0}; // resumes at remaining count
    vec[18] = '{1'b0, 1'b0, 1'b1, 1, 0, 1'b0};
    vec[19] = '{1'b1, 1'b0, 1'b0, 5, 7, 1'b0};
    vec[20] = '{1'b1, 1'b0, 1'b0, 4, 6, 1'b0};
    vec[21] = '{1'b1, 1'b0, 1'b0, 3, 6, 1'b0};  // next edge is a step
    vec[22] = '{1'b1, 1'b0, 1'b1, 1, 0, 1'b0};  // clr wins over step
    vec[23] = '{1'b0, 1'b0, 1'b0, 1, 0, 1'b1};  // blank one cycle later

    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_an", 32'(an), 32'hF);
    check("rst_sseg", 32'(sseg), 32'hFF);
    check("rst_pos", 32'(pos), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      en  = vec[i].en;
      dir = vec[i].dir;
      clr = vec[i].clr;
      repeat (vec[i].cyc) @(negedge clk);
      check($sformatf("vec%0d_pos", i), 32'(pos), 32'(vec[i].pos));
      if (vec[i].blank) begin
        check($sformatf("vec%0d_an_blank", i), 32'(an), 32'hF);
        check($sformatf("vec%0d_sseg_blank", i), 32'(sseg), 32'hFF);
      end
    end

    // Held square on a known digit: top on digit 1, top on digit 2, bottom on digit 2.
    go_to(1, 1'b1, 5);
    hold_look("hold_p1", 20, 4'b1101, TOP8, 1);
    go_to(2, 1'b1, 9);
    hold_look("hold_p2", 40, 4'b1011, TOP8, 2);
    go_to(5, 1'b0, 13);
    hold_look("hold_p5", 20, 4'b1011, BOT8, 5);

    // Reset in the middle of a rotation blanks immediately.
    clr = 1'b0; en = 1'b1; dir = 1'b1;
    repeat (7) @(negedge clk);
    #3 reset = 1'b1;
    #1;
    check("midrst_an", 32'(an), 32'hF);
    check("midrst_sseg", 32'(sseg), 32'hFF);
    check("midrst_pos", 32'(pos), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("post_rst_pos", 32'(pos), 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rotsq_disp_ctrl.md
Name: rotsq_disp_ctrl

Overview:
Parametrised rotating-square controller for the board's common-anode seven-segment display. It generalises the single-digit top/bottom square selector to NUM_DIGITS digits. A position counter drives a square around the top half of the digits and back along the bottom half, with run/hold/clear control and a direction input. It also time-multiplexes the anodes. It sits between the board switches and the AN/CA-CG/DP pins.

Parameters:
NUM_DIGITS, 4, digits in the loop; legal 2..8
TICK_DIV, 25_000_000, clk cycles per rotation step; must be >= 2
SCAN_DIV, 100_000, clk cycles each digit is refreshed in the scan; must be >= 1

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
en  in  1  1 = rotate, 0 = hold current position
dir  in  1  1 = position increments, 0 = position decrements
clr  in  1  synchronous return to IDLE with position 0; has priority over en
an  out  NUM_DIGITS  anodes, active-low, one-hot-low while scanning
sseg  out  8  {dp,g,f,e,d,c,b,a}, active-low
pos  out  $clog2(2*NUM_DIGITS)  current square position, for debug

Behaviour:
- Clocking and reset: one clock domain, clk. Reset is asynchronous and active-high. It forces state=IDLE, pos=0, tick_cnt=0, scan_cnt=0, scan_idx=0, an=all 1, sseg=8'hFF.
- States: IDLE (display blank), RUN, HOLD.
  - clr=1 in any state: go to IDLE, pos=0, tick_cnt=0.
  - IDLE to RUN when en=1.
  - RUN to HOLD when en=0.
  - HOLD to RUN when en=1.
- Step timing: tick_cnt counts 0..TICK_DIV-1 only in RUN. It holds its value in HOLD and clears in IDLE. On the RUN cycle where tick_cnt==TICK_DIV-1, tick_cnt wraps to 0 and pos steps.
  - dir is sampled on that cycle.
  - dir=1: pos = (pos==2N-1) ? 0 : pos+1.
  - dir=0: pos = (pos==0) ? 2N-1 : pos-1.
  - The first step occurs TICK_DIV cycles after entering RUN from IDLE.
- Position mapping (N = NUM_DIGITS):
  - pos<N: TOP square (a,b,f,g lit; g..a = 7'b0011100) on digit pos.
  - pos>=N: BOTTOM square (c,d,e,g lit; g..a = 7'b0100011) on digit 2N-1-pos.
- Scan: scan_cnt counts 0..SCAN_DIV-1 continuously in all states. At wrap, scan_idx advances mod NUM_DIGITS (wraps N-1 to 0).
- Outputs:
  - an is registered. In RUN/HOLD, an[scan_idx]=0 and all other bits are 1. In IDLE, an is all 1.
  - sseg is registered. It carries the square pattern when scan_idx equals the square's digit, otherwise 8'hFF. dp is always 1.
  - Output latency is 1 cycle from the state/pos/scan_idx registers.
- Simultaneous events:
  - clr and step on the same cycle: clr wins and pos=0.
  - en falling on the step cycle: the step is taken and the state goes to HOLD.
  - Reset mid-rotation: immediate blank and pos=0.

Optional Feature:
ROTSQ_HOLD_BLINK_EN
- Defined: in HOLD, the lit square blinks with a period of 2*TICK_DIV cycles, driven by a blink flag that toggles each TICK_DIV cycles. tick_cnt keeps counting in HOLD for this purpose only, and pos does not change. On entry to HOLD, tick_cnt and the blink flag clear so the square starts lit.
- Undefined: the square is lit steadily in HOLD and tick_cnt is frozen, as described in Behaviour.

Decomposition:
- Package rotsq_pkg contains:
  - typedef enum logic [1:0] {IDLE, RUN, HOLD} rotsq_state_t
  - constants SEG_TOP=7'b0011100, SEG_BOTTOM=7'b0100011, SEG_BLANK=8'hFF
  - function pos_to_digit(pos, n) returning {digit, side}
- One sub-module, rotsq_scan: holds scan_cnt/scan_idx and the anode decode, instantiated once.

Test Plan:
All scenarios use N=4, TICK_DIV=4, SCAN_DIV=2 unless stated.
- Reset then idle (en=0): an=4'hF and sseg=8'hFF for 50 cycles; pos=0.
- en=1, dir=1: pos steps 0,1,...,7,0 every 4 cycles. At pos=5 and scan_idx=2: an=4'b1011, sseg={1,7'b0100011}. At pos=1 and scan_idx=1: sseg={1,7'b0011100}.
- dir=0 from pos=0: next pos=7, then 6. The bottom square is on digit 0, then digit 1.
- en low for 20 cycles at pos=3: pos stays 3 and the square stays on digit 3. After en returns, the next step is at the remaining tick_cnt count.
- clr=1 on the same cycle as a step at pos=6: pos=0, state IDLE, and the display blank the next cycle. Separately, assert reset mid-scan: outputs are blank immediately.
- Compile with ROTSQ_HOLD_BLINK_EN, hold at pos=2: sseg on scan_idx=2 alternates between the TOP pattern and 8'hFF every 4 cycles. Without the macro it stays at the TOP pattern.
